mem_arbiter: RTL and testbench

Shared data-RAM responder for multi-core builds. Accepts read/write requests from `NCORES` cores, grants the single-port DRAM to one core at a time via the per-core `acq` handshake, and muxes address, data and write-enable to the RAM. Returns registered read data to the owning core. It sits between the cores' data-memory ports and the DRAM instance in the top level.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 31 +++
 rtl/mem_arbiter_rr_pick.sv | 31 +++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default parameters for the multi-core data-RAM arbiter.
package mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int MEMARB_NCORES_DEF  = 2;
  localparam int MEMARB_AW_DEF      = 8;
  localparam int MEMARB_DW_DEF      = 8;
  localparam int MEMARB_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response bundle plus the single-port DRAM side.
// Core i owns bit i of the vectors and slice [i*W +: W] of the buses.
interface mem_arbiter_if #(
  parameter int NCORES = 2,
  parameter int AW     = 8,
  parameter int DW     = 8
) ();

  logic [NCORES-1:0]    rden;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] Address;
  logic [NCORES*DW-1:0] Din;
  logic [DW-1:0]        RAMq;
  logic [NCORES-1:0]    acq;
  logic [NCORES*DW-1:0] Dq;
  logic [NCORES-1:0]    Dvalid;
  logic [AW-1:0]        RAMAddress;
  logic [DW-1:0]        RAMDin;
  logic                 RAMwren;

  modport slave (
    input  rden, wren, Address, Din, RAMq,
    output acq, Dq, Dvalid, RAMAddress, RAMDin, RAMwren
  );

  modport master (
    output rden, wren, Address, Din, RAMq,
    input  acq, Dq, Dvalid, RAMAddress, RAMDin, RAMwren
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter int NCORES = 2,
  parameter int IW     = 1
) (
  input  logic [NCORES-1:0] req_i,
  input  logic [IW-1:0]     last_i,
  output logic [NCORES-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  // Walk priorities from lowest to highest so the nearest requester after
  // 'last' is the final one written.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = NCORES; k >= 1; k--) begin
      for (int j = 0; j < NCORES; j++) begin
        if (req_i[j] && (j == (int'(last_i) + k) % NCORES)) begin
          gnt_o    = '0;
          gnt_o[j] = 1'b1;
          idx_o    = IW'(j);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port DRAM arbiter for NCORES cores with registered read return.
// Optional forced release after TIMEOUT grant cycles: MEMARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NCORES  = MEMARB_NCORES_DEF,
  parameter int AW      = MEMARB_AW_DEF,
  parameter int DW      = MEMARB_DW_DEF,
  parameter int TIMEOUT = MEMARB_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int IW = (NCORES > 2) ? 2 : 1;

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [NCORES-1:0]   acq_q, acq_d;
  logic                cap_vld_q, cap_vld_d;
  logic [IW-1:0]       cap_own_q, cap_own_d;
  logic [NCORES*DW-1:0] dq_q;
  logic [NCORES-1:0]   dvalid_q;

  logic [NCORES-1:0]   req;
  logic [NCORES-1:0]   pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                own_rd, own_wr;
  logic [AW-1:0]       own_addr;
  logic [DW-1:0]       own_din;
  logic                release_now;

`ifdef MEMARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                other_req;
`endif

  assign req = bus.rden | bus.wren;

  rr_pick #(.NCORES(NCORES), .IW(IW)) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    own_rd   = 1'b0;
    own_wr   = 1'b0;
    own_addr = bus.Address[AW-1:0];
    own_din  = bus.Din[DW-1:0];
`ifdef MEMARB_TIMEOUT_EN
    other_req = 1'b0;
`endif
    for (int i = 0; i < NCORES; i++) begin
      if (owner_q == IW'(i)) begin
        own_rd   = bus.rden[i];
        own_wr   = bus.wren[i];
        own_addr = bus.Address[i*AW +: AW];
        own_din  = bus.Din[i*DW +: DW];
      end
`ifdef MEMARB_TIMEOUT_EN
      else begin
        other_req = other_req | req[i];
      end
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    acq_d       = acq_q;
    cap_vld_d   = 1'b0;
    cap_own_d   = owner_q;
    release_now = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          owner_d = pick_idx;
          acq_d   = pick_gnt;
`ifdef MEMARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // A simultaneous write takes the cycle, so nothing is captured.
        cap_vld_d = own_rd & ~own_wr;
        if (!(own_rd | own_wr)) begin
          release_now = 1'b1;
        end
`ifdef MEMARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          release_now = other_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (release_now) begin
          state_d = ARB_IDLE;
          acq_d   = '0;
          last_d  = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      last_q    <= IW'(NCORES - 1);
      acq_q     <= '0;
      cap_vld_q <= 1'b0;
      cap_own_q <= '0;
      dq_q      <= '0;
      dvalid_q  <= '0;
`ifdef MEMARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      acq_q     <= acq_d;
      cap_vld_q <= cap_vld_d;
      cap_own_q <= cap_own_d;
      dvalid_q  <= '0;
      for (int i = 0; i < NCORES; i++) begin
        if (cap_vld_q && (cap_own_q == IW'(i))) begin
          dq_q[i*DW +: DW] <= bus.RAMq;
          dvalid_q[i]      <= 1'b1;
        end
      end
`ifdef MEMARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.acq        = acq_q;
  assign bus.Dq         = dq_q;
  assign bus.Dvalid     = dvalid_q;
  assign bus.RAMAddress = (state_q == ARB_GRANT) ? own_addr : bus.Address[AW-1:0];
  assign bus.RAMDin     = (state_q == ARB_GRANT) ? own_din  : bus.Din[DW-1:0];
  assign bus.RAMwren    = (|(acq_q & bus.wren)) & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int NC = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.NCORES(NC), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // DRAM stand-in: synchronous write, registered read.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.RAMwren) ram[bus.RAMAddress] <= bus.RAMDin;
    bus.RAMq <= ram[bus.RAMAddress];
  end

  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  int            n_chk = 0;
  int            n_fail = 0;
  int            own, last, gcnt, cyc, own_cur;
  logic [DW-1:0] mmem [256];
  logic [DW-1:0] exp_dq [NC];
  rd_t           rq [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    own  = -1;
    last = NC - 1;
    gcnt = 0;
    rq.delete();
    for (int c = 0; c < NC; c++) exp_dq[c] = '0;
  endtask

  task automatic set_core(input int c, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.rden[c]            = rd;
    bus.wren[c]            = wr;
    bus.Address[c*AW +: AW] = a;
    bus.Din[c*DW +: DW]     = d;
  endtask

  task automatic clear_all();
    for (int c = 0; c < NC; c++) set_core(c, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock cycle: compare outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [NC-1:0]    rd, wr, req, exp_acq, exp_dv;
    logic [NC*DW-1:0] exp_flat;
    logic [AW-1:0]    exp_addr, a;
    logic [DW-1:0]    exp_din, d;
    logic             exp_we;
    bit               found;
    @(negedge clk);
    rd  = bus.rden;
    wr  = bus.wren;
    req = rd | wr;
    exp_dv = '0;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      exp_dq[rq[0].core] = rq[0].data;
      exp_dv[rq[0].core] = 1'b1;
      void'(rq.pop_front());
    end
    for (int c = 0; c < NC; c++) exp_flat[c*DW +: DW] = exp_dq[c];
    exp_acq = '0;
    if (own >= 0) exp_acq[own] = 1'b1;
    if (own >= 0) begin
      exp_addr = bus.Address[own*AW +: AW];
      exp_din  = bus.Din[own*DW +: DW];
      exp_we   = wr[own] & ~rst;
    end else begin
      exp_addr = bus.Address[AW-1:0];
      exp_din  = bus.Din[DW-1:0];
      exp_we   = 1'b0;
    end
    check("acq",        64'(bus.acq),        64'(exp_acq));
    check("RAMwren",    64'(bus.RAMwren),    64'(exp_we));
    check("RAMAddress", 64'(bus.RAMAddress), 64'(exp_addr));
    check("RAMDin",     64'(bus.RAMDin),     64'(exp_din));
    check("Dvalid",     64'(bus.Dvalid),     64'(exp_dv));
    check("Dq",         64'(bus.Dq),         64'(exp_flat));
    own_cur = own;
    if (rst) begin
      model_reset();
    end else if (own >= 0) begin
      a = bus.Address[own*AW +: AW];
      d = bus.Din[own*DW +: DW];
      if (wr[own]) mmem[a] = d;
      else if (rd[own]) rq.push_back('{own, mmem[a], cyc + 2});
      if (!req[own]) begin
        last = own;
        own  = -1;
      end
`ifdef MEMARB_TIMEOUT_EN
      else if (gcnt == TO - 1) begin
        logic [NC-1:0] others;
        others = req;
        others[own] = 1'b0;
        if (others != '0) begin
          last = own;
          own  = -1;
        end
      end else begin
        gcnt++;
      end
`endif
    end else begin
      found = 1'b0;
      for (int k = 1; k <= NC; k++) begin
        if (!found && req[(last + k) % NC]) begin
          own   = (last + k) % NC;
          gcnt  = 0;
          found = 1'b1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  int blen [NC];
  int bop  [NC];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]  = '0;
      mmem[i] = '0;
    end
    bus.rden = '0; bus.wren = '0; bus.Address = '0; bus.Din = '0;
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset, single write, read back.
    do_reset();
    set_core(0, 1'b0, 1'b1, 8'h10, 8'hA5);
    cycle();
    check("plan_grant_lat", 64'(bus.acq), 64'(2'b01));
    cycle();
    clear_all();
    cycle();
    check("plan_release", 64'(bus.acq), 64'(2'b00));
    set_core(0, 1'b1, 1'b0, 8'h10, 8'h00);
    cycle();
    cycle();
    clear_all();
    cycle();
    check("plan_rd_dq0", 64'(bus.Dq[7:0]), 64'(8'hA5));
    check("plan_rd_dv",  64'(bus.Dvalid),  64'(2'b01));
    cycle();

    // Simultaneous requests from reset: core 0 first, core 1 two cycles after drop.
    do_reset();
    set_core(0, 1'b1, 1'b0, 8'h30, 8'h00);
    set_core(1, 1'b1, 1'b0, 8'h31, 8'h00);
    cycle();
    check("plan_tie_c0", 64'(bus.acq), 64'(2'b01));
    set_core(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycle();
    check("plan_gap", 64'(bus.acq), 64'(2'b00));
    cycle();
    check("plan_c1_after", 64'(bus.acq), 64'(2'b10));
    clear_all();
    cycle();
    cycle();

    // Read and write together: write wins, no read return.
    set_core(0, 1'b1, 1'b1, 8'h20, 8'h3C);
    cycle();
    cycle();
    clear_all();
    cycle();
    check("plan_rw_nodv", 64'(bus.Dvalid), 64'(2'b00));
    set_core(0, 1'b1, 1'b0, 8'h20, 8'h00);
    cycle();
    cycle();
    clear_all();
    cycle();
    check("plan_rw_dq0", 64'(bus.Dq[7:0]), 64'(8'h3C));
    cycle();

    // Reset while a read is in flight.
    do_reset();
    set_core(1, 1'b0, 1'b1, 8'h40, 8'h5A);
    cycle();
    cycle();
    clear_all();
    cycle();
    set_core(1, 1'b1, 1'b0, 8'h40, 8'h00);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_all();
    check("plan_rst_acq", 64'(bus.acq),    64'(2'b00));
    check("plan_rst_dv",  64'(bus.Dvalid), 64'(2'b00));
    check("plan_rst_dq",  64'(bus.Dq),     64'(16'h0000));
    cycle();
    check("plan_rst_dv2", 64'(bus.Dvalid), 64'(2'b00));

`ifdef MEMARB_TIMEOUT_EN
    // Forced release while another core waits.
    do_reset();
    set_core(0, 1'b1, 1'b0, 8'h50, 8'h00);
    cycle();
    set_core(1, 1'b1, 1'b0, 8'h51, 8'h00);
    repeat (4) cycle();
    check("plan_to_drop", 64'(bus.acq), 64'(2'b00));
    cycle();
    check("plan_to_next", 64'(bus.acq), 64'(2'b10));
    clear_all();
    cycle();
    cycle();
`endif

    // Random bursts with occasional resets.
    for (int c = 0; c < NC; c++) begin
      blen[c] = 0;
      bop[c]  = 0;
    end
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < NC; c++) begin
        if (blen[c] == 0 && $urandom_range(0, 2) == 0) begin
          blen[c] = $urandom_range(1, 4);
          bop[c]  = $urandom_range(0, 2);
        end
        if (blen[c] > 0)
          set_core(c, bop[c] != 1, bop[c] != 0, 8'h10 + 8'($urandom_range(0, 7)), 8'($urandom));
        else
          set_core(c, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
      end
      cycle();
      for (int c = 0; c < NC; c++) begin
        if (own_cur == c && blen[c] > 0) blen[c]--;
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
